// File: rtl/wb_writeback_stage.sv
// wb_writeback_stage: writeback stage owning the register file write port.
// Accepts MEM/WB bundles over a valid/ready handshake, waits for the
// data-memory response on loads, extracts and extends the loaded value,
// and issues exactly one registered write pulse per instruction.
//
// Optional feature (macro WB_FWD_EN): adds id_rs1/id_rs2 inputs and
// fwd_rs1_hit/fwd_rs2_hit/fwd_data outputs, so ID can bypass the register
// file during the cycle a write is pending.
//
// Handshake: a bundle is accepted on a rising clk edge where
// in_valid & in_ready are both 1. in_ready is a pure function of state
// (1 in IDLE and WRITE, 0 in WAIT_LOAD). The upstream stage must hold its
// bundle stable while in_valid=1 and in_ready=0.
//
// state_dbg exposes the FSM state: 0=IDLE, 1=WAIT_LOAD, 2=WRITE.

module wb_writeback_stage #(
   parameter int XLEN = 32,
   parameter int REGS = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [$clog2(REGS)-1:0]   in_rd,
   input  logic                      in_wer,
   input  logic                      in_is_load,
   input  logic [2:0]                in_funct3,
   input  logic [1:0]                in_addr_lo,
   input  logic [XLEN-1:0]           in_result,
   input  logic                      mem_rsp_valid,
   input  logic [XLEN-1:0]           mem_rsp_data,
   output logic                      wer,
   output logic [$clog2(REGS)-1:0]   rd,
   output logic [XLEN-1:0]           regdata,
   output logic                      retire,
   output logic                      err_unexp_rsp,
`ifdef WB_FWD_EN
   input  logic [$clog2(REGS)-1:0]   id_rs1,
   input  logic [$clog2(REGS)-1:0]   id_rs2,
   output logic                      fwd_rs1_hit,
   output logic                      fwd_rs2_hit,
   output logic [XLEN-1:0]           fwd_data,
`endif
   output logic [1:0]                state_dbg
);

   localparam int RW = $clog2(REGS);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LOAD = 2'd1,
      WRITE     = 2'd2
   } state_t;

   state_t          state;

   // Load attributes captured at accept time, used when the response arrives.
   logic [RW-1:0]   l_rd;
   logic            l_wer;
   logic [2:0]      l_funct3;
   logic [1:0]      l_addr_lo;

   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] load_data;

   assign in_ready  = (state != WAIT_LOAD);
   assign state_dbg = state;

   // Select the byte/half lane and extend according to the latched load type.
   always_comb begin
      byte_sel  = 8'h00;
      half_sel  = 16'h0000;
      load_data = mem_rsp_data;
      case (l_addr_lo)
         2'd0:    byte_sel = mem_rsp_data[7:0];
         2'd1:    byte_sel = mem_rsp_data[15:8];
         2'd2:    byte_sel = mem_rsp_data[23:16];
         default: byte_sel = mem_rsp_data[31:24];
      endcase
      // Misaligned halves are not trapped here; only addr_lo[1] picks the lane.
      half_sel = l_addr_lo[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
      case (l_funct3)
         3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
         default: load_data = mem_rsp_data;   // LW and undefined codes
      endcase
   end

   // Writeback FSM with registered write-port outputs and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         wer           <= 1'b0;
         rd            <= '0;
         regdata       <= '0;
         retire        <= 1'b0;
         err_unexp_rsp <= 1'b0;
         l_rd          <= '0;
         l_wer         <= 1'b0;
         l_funct3      <= 3'b000;
         l_addr_lo     <= 2'b00;
      end else begin
         // A response is only expected while waiting on a load; anything else
         // (including one coinciding with a new load accept) is flagged.
         if (mem_rsp_valid && (state != WAIT_LOAD))
            err_unexp_rsp <= 1'b1;

         case (state)
            IDLE, WRITE: begin
               if (in_valid) begin
                  if (in_is_load) begin
                     state     <= WAIT_LOAD;
                     l_rd      <= in_rd;
                     l_wer     <= in_wer;
                     l_funct3  <= in_funct3;
                     l_addr_lo <= in_addr_lo;
                     wer       <= 1'b0;
                     retire    <= 1'b0;
                  end else begin
                     state   <= WRITE;
                     wer     <= in_wer & (in_rd != '0);
                     rd      <= in_rd;
                     regdata <= in_result;
                     retire  <= 1'b1;
                  end
               end else begin
                  // rd and regdata keep their last value.
                  state  <= IDLE;
                  wer    <= 1'b0;
                  retire <= 1'b0;
               end
            end
            WAIT_LOAD: begin
               if (mem_rsp_valid) begin
                  state   <= WRITE;
                  wer     <= l_wer & (l_rd != '0);
                  rd      <= l_rd;
                  regdata <= load_data;
                  retire  <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               wer    <= 1'b0;
               retire <= 1'b0;
            end
         endcase
      end
   end

`ifdef WB_FWD_EN
   // Bypass from the pending write, derived from the registered outputs.
   assign fwd_rs1_hit = wer & (rd == id_rs1);
   assign fwd_rs2_hit = wer & (rd == id_rs2);
   assign fwd_data    = regdata;
`endif

endmodule

// File: tb/tb_wb_writeback_stage.sv
// Testbench for wb_writeback_stage: directed vectors with hand-computed
// expectations plus a transaction-level reference model compared every cycle.

module tb_wb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_wer;
   logic        in_is_load;
   logic [2:0]  in_funct3;
   logic [1:0]  in_addr_lo;
   logic [31:0] in_result;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        wer;
   logic [4:0]  rd;
   logic [31:0] regdata;
   logic        retire;
   logic        err_unexp_rsp;
   logic [1:0]  state_dbg;
`ifdef WB_FWD_EN
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        fwd_rs1_hit;
   logic        fwd_rs2_hit;
   logic [31:0] fwd_data;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   wb_writeback_stage #(.XLEN(32), .REGS(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rd         (in_rd),
      .in_wer        (in_wer),
      .in_is_load    (in_is_load),
      .in_funct3     (in_funct3),
      .in_addr_lo    (in_addr_lo),
      .in_result     (in_result),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .wer           (wer),
      .rd            (rd),
      .regdata       (regdata),
      .retire        (retire),
      .err_unexp_rsp (err_unexp_rsp),
`ifdef WB_FWD_EN
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .fwd_rs1_hit   (fwd_rs1_hit),
      .fwd_rs2_hit   (fwd_rs2_hit),
      .fwd_data      (fwd_data),
`endif
      .state_dbg     (state_dbg)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
   endtask

   // ---------------- reference model ----------------
   // Tracks "a load is outstanding" plus what the write port must show.
   logic        m_pending;
   logic [4:0]  m_rd_l;
   logic        m_wer_l;
   logic [2:0]  m_f3_l;
   logic [1:0]  m_lo_l;
   logic        m_wer, m_retire, m_err;
   logic [4:0]  m_rd;
   logic [31:0] m_data;

   function automatic logic [31:0] model_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'((w >> (8 * int'(lo))) & 32'hFF);
      h = 16'((w >> (16 * int'(lo[1]))) & 32'hFFFF);
      case (f3)
         3'b000:  return 32'($signed(b));
         3'b001:  return 32'($signed(h));
         3'b100:  return 32'(b);
         3'b101:  return 32'(h);
         default: return w;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pending = 1'b0; m_wer = 1'b0; m_retire = 1'b0; m_err = 1'b0;
         m_rd = 5'd0; m_data = 32'd0;
         m_rd_l = 5'd0; m_wer_l = 1'b0; m_f3_l = 3'd0; m_lo_l = 2'd0;
      end else if (m_pending) begin
         if (mem_rsp_valid) begin
            m_pending = 1'b0;
            m_rd      = m_rd_l;
            m_wer     = m_wer_l && (m_rd_l != 5'd0);
            m_data    = model_extract(m_f3_l, m_lo_l, mem_rsp_data);
            m_retire  = 1'b1;
         end
      end else begin
         if (mem_rsp_valid) m_err = 1'b1;
         if (in_valid && in_is_load) begin
            m_pending = 1'b1;
            m_rd_l = in_rd; m_wer_l = in_wer; m_f3_l = in_funct3; m_lo_l = in_addr_lo;
            m_wer = 1'b0; m_retire = 1'b0;
         end else if (in_valid) begin
            m_rd     = in_rd;
            m_wer    = in_wer && (in_rd != 5'd0);
            m_data   = in_result;
            m_retire = 1'b1;
         end else begin
            m_wer = 1'b0; m_retire = 1'b0;
         end
      end
   end

   // ---------------- scoreboard: compare every cycle ----------------
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         chk("cyc_wer", {31'd0, wer}, {31'd0, m_wer});
         chk("cyc_retire", {31'd0, retire}, {31'd0, m_retire});
         chk("cyc_err", {31'd0, err_unexp_rsp}, {31'd0, m_err});
         chk("cyc_ready", {31'd0, in_ready}, {31'd0, !m_pending});
         chk("cyc_rd", {27'd0, rd}, {27'd0, m_rd});
         chk("cyc_regdata", regdata, m_data);
`ifdef WB_FWD_EN
         chk("cyc_fwd1", {31'd0, fwd_rs1_hit}, {31'd0, m_wer && (m_rd == id_rs1)});
         chk("cyc_fwd2", {31'd0, fwd_rs2_hit}, {31'd0, m_wer && (m_rd == id_rs2)});
         chk("cyc_fwd_data", fwd_data, m_data);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      in_valid = 1'b0; in_rd = 5'd0; in_wer = 1'b0; in_is_load = 1'b0;
      in_funct3 = 3'd0; in_addr_lo = 2'd0; in_result = 32'd0;
      mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
   endtask

   task automatic drive_alu(input logic [4:0] r, input logic w, input logic [31:0] res);
      in_valid = 1'b1; in_is_load = 1'b0; in_rd = r; in_wer = w; in_result = res;
   endtask

   task automatic do_load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [31:0] word, input logic [31:0] expv);
      @(negedge clk);
      in_valid = 1'b1; in_is_load = 1'b1; in_wer = 1'b1; in_rd = r;
      in_funct3 = f3; in_addr_lo = lo;
      @(negedge clk);
      in_valid = 1'b0; in_is_load = 1'b0;
      chk("ld_ready_wait", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("ld_no_early_wer", {31'd0, wer}, 32'd0);
      mem_rsp_valid = 1'b1; mem_rsp_data = word;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("ld_data", regdata, expv);
      chk("ld_wer", {31'd0, wer}, 32'd1);
      chk("ld_rd", {27'd0, rd}, {27'd0, r});
      @(negedge clk);
      chk("ld_wer_drop", {31'd0, wer}, 32'd0);
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [31:0] word;
      logic [31:0] expv;
   } ld_vec_t;

   ld_vec_t ld_tab[$];

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
`ifdef WB_FWD_EN
      id_rs1 = 5'd0; id_rs2 = 5'd0;
`endif
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wer", {31'd0, wer}, 32'd0);
      chk("rst_rd", {27'd0, rd}, 32'd0);
      chk("rst_regdata", regdata, 32'd0);
      chk("rst_retire", {31'd0, retire}, 32'd0);
      chk("rst_err", {31'd0, err_unexp_rsp}, 32'd0);
      chk("rst_state", {30'd0, state_dbg}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // pin the model against hand-computed values
      chk("model_lb3", model_extract(3'b000, 2'd3, 32'h80FF7F01), 32'hFFFFFF80);
      chk("model_lhu0", model_extract(3'b101, 2'd0, 32'h8001FFFE), 32'h0000FFFE);

      // single ALU write
      @(negedge clk);
      drive_alu(5'd7, 1'b1, 32'h12345678);
      @(negedge clk);
      in_valid = 1'b0;
      chk("alu_wer", {31'd0, wer}, 32'd1);
      chk("alu_rd", {27'd0, rd}, 32'd7);
      chk("alu_data", regdata, 32'h12345678);
      chk("alu_retire", {31'd0, retire}, 32'd1);
      @(negedge clk);
      chk("alu_retire_once", {31'd0, retire}, 32'd0);
      chk("alu_data_hold", regdata, 32'h12345678);

      // back-to-back to x1, x2, x0
      @(negedge clk);
      drive_alu(5'd1, 1'b1, 32'h11111111);
      @(negedge clk);
      chk("b2b1_wer", {31'd0, wer}, 32'd1);
      chk("b2b1_ready", {31'd0, in_ready}, 32'd1);
      drive_alu(5'd2, 1'b1, 32'h22222222);
      @(negedge clk);
      chk("b2b2_wer", {31'd0, wer}, 32'd1);
      chk("b2b2_data", regdata, 32'h22222222);
      chk("b2b2_ready", {31'd0, in_ready}, 32'd1);
      drive_alu(5'd0, 1'b1, 32'h33333333);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b3_wer_x0", {31'd0, wer}, 32'd0);
      chk("b2b3_retire", {31'd0, retire}, 32'd1);
      @(negedge clk);
      chk("b2b_end_retire", {31'd0, retire}, 32'd0);

      // load extraction table
      ld_tab.push_back('{3'b000, 2'd3, 32'h80FF7F01, 32'hFFFFFF80});
      ld_tab.push_back('{3'b100, 2'd3, 32'h80FF7F01, 32'h00000080});
      ld_tab.push_back('{3'b000, 2'd1, 32'h80FF7F01, 32'h0000007F});
      ld_tab.push_back('{3'b001, 2'd2, 32'h8001FFFE, 32'hFFFF8001});
      ld_tab.push_back('{3'b101, 2'd0, 32'h8001FFFE, 32'h0000FFFE});
      ld_tab.push_back('{3'b001, 2'd0, 32'h8001FFFE, 32'hFFFFFFFE});
      ld_tab.push_back('{3'b010, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF});
      ld_tab.push_back('{3'b110, 2'd2, 32'h0BADF00D, 32'h0BADF00D});
      ld_tab.push_back('{3'b101, 2'd3, 32'hA5C3_1234, 32'h0000A5C3});
      foreach (ld_tab[i])
         do_load(5'(10 + i), ld_tab[i].f3, ld_tab[i].lo, ld_tab[i].word, ld_tab[i].expv);

      // response on the same edge a load is accepted: unexpected, load still waits
      @(negedge clk);
      in_valid = 1'b1; in_is_load = 1'b1; in_wer = 1'b1; in_rd = 5'd3;
      in_funct3 = 3'b010; in_addr_lo = 2'd0;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55555555;
      @(negedge clk);
      in_valid = 1'b0; in_is_load = 1'b0; mem_rsp_valid = 1'b0;
      chk("same_edge_err", {31'd0, err_unexp_rsp}, 32'd1);
      chk("same_edge_wait", {31'd0, in_ready}, 32'd0);
      chk("same_edge_no_wer", {31'd0, wer}, 32'd0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEBABE;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("same_edge_data", regdata, 32'hCAFEBABE);
      chk("same_edge_wer", {31'd0, wer}, 32'd1);

      // reset mid-load
      @(negedge clk);
      in_valid = 1'b1; in_is_load = 1'b1; in_wer = 1'b1; in_rd = 5'd5;
      in_funct3 = 3'b010; in_addr_lo = 2'd0;
      @(negedge clk);
      in_valid = 1'b0; in_is_load = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_wer", {31'd0, wer}, 32'd0);
      chk("midrst_rd", {27'd0, rd}, 32'd0);
      chk("midrst_regdata", regdata, 32'd0);
      chk("midrst_err", {31'd0, err_unexp_rsp}, 32'd0);
      chk("midrst_state", {30'd0, state_dbg}, 32'd0);
      chk("midrst_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0005;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("midrst_late_err", {31'd0, err_unexp_rsp}, 32'd1);
      chk("midrst_no_wer", {31'd0, wer}, 32'd0);
      chk("midrst_no_retire", {31'd0, retire}, 32'd0);

      // stray response in IDLE after a clean reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("stray_pre_err", {31'd0, err_unexp_rsp}, 32'd0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFFFFFF;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("stray_err", {31'd0, err_unexp_rsp}, 32'd1);
      chk("stray_no_wer", {31'd0, wer}, 32'd0);
      repeat (3) @(negedge clk);
      chk("stray_sticky", {31'd0, err_unexp_rsp}, 32'd1);

`ifdef WB_FWD_EN
      // bypass during the write cycle
      id_rs1 = 5'd3; id_rs2 = 5'd9;
      drive_alu(5'd9, 1'b1, 32'h0F0F1234);
      @(negedge clk);
      in_valid = 1'b0;
      chk("fwd_rs2_hit", {31'd0, fwd_rs2_hit}, 32'd1);
      chk("fwd_rs1_miss", {31'd0, fwd_rs1_hit}, 32'd0);
      chk("fwd_data", fwd_data, 32'h0F0F1234);
      @(negedge clk);
      chk("fwd_rs2_drop", {31'd0, fwd_rs2_hit}, 32'd0);
`endif

      // a few random ALU ops, checked by the per-cycle model
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(0, 1));
         in_is_load = 1'b0;
         in_rd = 5'($urandom_range(0, 31));
         in_wer = 1'($urandom_range(0, 1));
         in_result = $urandom;
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_writeback_stage.md
Name: wb_writeback_stage

Overview:
- Writeback stage that owns the register file write port (wer, rd, regdata).
- Accepts completed instructions from MEM over a valid/ready handshake.
- For loads, waits for the data-memory response, then extracts and sign- or zero-extends the data.
- Issues exactly one registered write pulse per instruction; the register file commits it on the following rising clk edge.

Parameters:
- XLEN, 32, data width of results, memory response and regdata.
- REGS, 32, architectural register count; rd width = $clog2(REGS).

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  MEM/WB bundle valid
- in_ready  out  1  stage can accept a bundle this cycle
- in_rd  in  5  destination register
- in_wer  in  1  instruction writes a register
- in_is_load  in  1  result comes from data memory
- in_funct3  in  3  load type
- in_addr_lo  in  2  load address bits [1:0]
- in_result  in  XLEN  ALU/PC+4 result (non-load)
- mem_rsp_valid  in  1  data-memory response valid (single-cycle pulse)
- mem_rsp_data  in  XLEN  raw aligned word from data memory
- wer  out  1  register file write enable
- rd  out  5  register file write address
- regdata  out  XLEN  register file write data
- retire  out  1  one-cycle pulse per completed instruction
- err_unexp_rsp  out  1  sticky: mem_rsp_valid arrived while not waiting

Behaviour:
- Reset (async, any state): state=IDLE; wer=0, rd=0, regdata=0, retire=0, err_unexp_rsp=0. A load in flight is discarded with no write.
- States: IDLE, WAIT_LOAD, WRITE.
- in_ready=1 in IDLE and WRITE; 0 in WAIT_LOAD.
- Accept means in_valid & in_ready at a rising edge.
- Non-load accepted at edge N: state->WRITE; at edge N drive wer=in_wer&(in_rd!=0), rd=in_rd, regdata=in_result, retire=1. Outputs are visible during cycle N+1.
- Load accepted: state->WAIT_LOAD; latch rd, in_wer, funct3, addr_lo.
- WAIT_LOAD:
  - Hold until mem_rsp_valid.
  - On that edge, drive extracted data on regdata, wer as above, retire=1; state->WRITE.
  - No timeout.
- WRITE:
  - Outputs stay valid for exactly one cycle.
  - Next edge with a new accept: same rules as IDLE, giving back-to-back writes at 1/cycle.
  - Next edge without an accept: state->IDLE; wer=0, retire=0. rd and regdata hold their last value.
- rd==0: wer forced 0; retire still pulses.
- Load extraction, with byte lane b=addr_lo and half lane h=addr_lo[1]:
  - 000 LB: sign-extend byte b.
  - 001 LH: sign-extend half h.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte b.
  - 101 LHU: zero-extend half h.
  - Other funct3 codes: treated as LW.
  - Misalignment is ignored: LH/LHU use only addr_lo[1]; LW ignores addr_lo.
- mem_rsp_valid in IDLE or WRITE: response ignored; err_unexp_rsp set to 1 and held until rst.
- mem_rsp_valid on the same edge a load is accepted from IDLE/WRITE: counts as unexpected. The new load still waits for a later response.
- Only WB drives the write port; no other writer exists.

Optional Feature:
- Macro: WB_FWD_EN.
- With WB_FWD_EN:
  - Adds inputs id_rs1[4:0] and id_rs2[4:0].
  - Adds outputs fwd_rs1_hit, fwd_rs2_hit and fwd_data[XLEN].
  - fwd_rsX_hit = wer & (rd==id_rsX), combinational from the registered outputs.
  - fwd_data = regdata.
  - Lets ID bypass the register file during the cycle the write is pending.
- Without WB_FWD_EN: these ports and their logic do not exist; behaviour is otherwise identical.

Test Plan:
- Reset mid-load: accept LW rd=5, assert rst async before the response -> wer=0 and state IDLE immediately. A later mem_rsp_valid sets err_unexp_rsp=1; no write to x5.
- ALU write: in_valid, in_rd=7, in_wer=1, in_result=0x1234_5678 -> next cycle wer=1, rd=7, regdata=0x12345678, retire=1 for exactly one cycle.
- Back-to-back: three ALU ops to x1, x2, x0 on consecutive cycles -> three consecutive retire pulses. wer=1,1,0; in_ready stays 1.
- LB/LBU lanes: mem_rsp_data=0x80FF_7F01.
  - LB addr_lo=3 -> 0xFFFFFF80.
  - LBU addr_lo=3 -> 0x00000080.
  - LB addr_lo=1 -> 0x0000007F.
  - in_ready=0 while waiting; write lands the cycle after mem_rsp_valid.
- LH/LHU: mem_rsp_data=0x8001_FFFE.
  - LH addr_lo=2 -> 0xFFFF8001.
  - LHU addr_lo=0 -> 0x0000FFFE.
  - LH addr_lo=0 -> 0xFFFFFFFE.
- Stray response: mem_rsp_valid pulse in IDLE -> err_unexp_rsp=1 sticky; no wer. With WB_FWD_EN, ALU write to x9 with id_rs2=9 -> fwd_rs2_hit=1 and fwd_data=result in the write cycle.
